// File: rtl/prog_memory_pkg.sv
// Shared types and defaults for the writable program memory.
// DEPTH is derived from the address width so every user agrees on it.
package prog_memory_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOAD = 1'b1
   } state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_ADDR_W = 4;
   localparam logic [DEF_DATA_W-1:0] DEF_NOP_WORD = 8'h00;

   function automatic int depth_of(input int addr_w);
      return 1 << addr_w;
   endfunction

   localparam int DEF_DEPTH = depth_of(DEF_ADDR_W);

endpackage

// File: rtl/prog_mem_array.sv
// DEPTH x DATA_W program storage: one synchronous write port and one
// enabled, registered read port. Contents are deliberately not reset.
module prog_mem_array
   import prog_memory_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = depth_of(ADDR_W);

   logic [DATA_W-1:0] mem [DEPTH];

   // rdata only moves on an accepted fetch, so it holds between fetches
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/prog_memory.sv
// Writable program memory: run-time load port, one-cycle fetch port, and
// NOP masking of every address at or beyond the loaded program length.
//
//   state | meaning
//   IDLE  | fetches accepted, load port closed; load_start opens a load
//   LOAD  | words streamed in from address 0, fetches refused
module prog_memory
   import prog_memory_pkg::*;
#(
   parameter int                DATA_W   = DEF_DATA_W,
   parameter int                ADDR_W   = DEF_ADDR_W,
   parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEF_NOP_WORD)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_addr,
   output logic              fetch_ready,
   output logic [DATA_W-1:0] instr,
   output logic              instr_valid,
   input  logic              load_start,
   input  logic              load_valid,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_last,
   output logic              load_ready,
   output logic              load_done,
   output logic              load_err,
   output logic [ADDR_W:0]   prog_len
);

   localparam int                DEPTH     = depth_of(ADDR_W);
   localparam logic [ADDR_W:0]   DEPTH_LEN = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0]   LEN_ONE   = (ADDR_W+1)'(1);
   localparam logic [ADDR_W-1:0] PTR_ONE   = ADDR_W'(1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   state_t            state;
   logic [ADDR_W-1:0] wr_ptr;
   logic              nop_sel;
   logic [DATA_W-1:0] rd_data;
   logic              fetch_ok;
   logic              wr_en;
   logic              in_range;

   assign fetch_ready = (state == IDLE);
   assign load_ready  = (state == LOAD);
   assign fetch_ok    = fetch_en & fetch_ready;
   assign wr_en       = load_valid & load_ready;
   assign in_range    = ({1'b0, fetch_addr} < prog_len);

   prog_mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata (load_data),
      .re    (fetch_ok),
      .raddr (fetch_addr),
      .rdata (rd_data)
   );

   // The range decision is captured with the read so instr and its mask
   // always refer to the same fetch; nop_sel starts set so reset shows NOP.
   assign instr = nop_sel ? NOP_WORD : rd_data;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         wr_ptr      <= '0;
         prog_len    <= DEPTH_LEN;
         load_done   <= 1'b0;
         load_err    <= 1'b0;
         instr_valid <= 1'b0;
         nop_sel     <= 1'b1;
      end else begin
         load_done   <= 1'b0;
         instr_valid <= fetch_ok;
         if (fetch_ok) begin
            nop_sel <= ~in_range;
         end
         case (state)
            IDLE: begin
               if (load_start) begin
                  state    <= LOAD;
                  wr_ptr   <= '0;
                  load_err <= 1'b0;
               end
            end
            LOAD: begin
               if (load_valid) begin
                  wr_ptr <= wr_ptr + PTR_ONE;
                  if (load_last) begin
                     prog_len  <= {1'b0, wr_ptr} + LEN_ONE;
                     load_done <= 1'b1;
                     state     <= IDLE;
                  end else if (wr_ptr == LAST_ADDR) begin
                     prog_len  <= DEPTH_LEN;
                     load_err  <= 1'b1;
                     load_done <= 1'b1;
                     state     <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_prog_memory.sv
// Directed, table-driven bench for prog_memory: load sequences driven by
// hand, fetch results compared against a table of hand-computed words.
module tb_prog_memory;

   logic       clk = 1'b0;
   logic       reset;
   logic       fetch_en;
   logic [3:0] fetch_addr;
   logic       fetch_ready;
   logic [7:0] instr;
   logic       instr_valid;
   logic       load_start;
   logic       load_valid;
   logic [7:0] load_data;
   logic       load_last;
   logic       load_ready;
   logic       load_done;
   logic       load_err;
   logic [4:0] prog_len;

   int errors = 0;
   int checks = 0;

   typedef struct {
      int         phase;
      logic [3:0] addr;
      logic [7:0] exp;
   } vec_t;

   vec_t       vecs[$];
   logic [7:0] words[16];

   prog_memory dut (
      .clk         (clk),
      .reset       (reset),
      .fetch_en    (fetch_en),
      .fetch_addr  (fetch_addr),
      .fetch_ready (fetch_ready),
      .instr       (instr),
      .instr_valid (instr_valid),
      .load_start  (load_start),
      .load_valid  (load_valid),
      .load_data   (load_data),
      .load_last   (load_last),
      .load_ready  (load_ready),
      .load_done   (load_done),
      .load_err    (load_err),
      .prog_len    (prog_len)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vecs(input int ph);
      foreach (vecs[i]) begin
         if (vecs[i].phase == ph) begin
            fetch_en   = 1'b1;
            fetch_addr = vecs[i].addr;
            step();
            fetch_en = 1'b0;
            check($sformatf("p%0d valid@%0d", ph, vecs[i].addr), 32'(instr_valid), 32'd1);
            check($sformatf("p%0d instr@%0d", ph, vecs[i].addr), 32'(instr), 32'(vecs[i].exp));
         end
      end
   endtask

   // Streams words[0..n-1]; optional idle gaps with blocked fetch attempts,
   // optional fetch issued in the load_start cycle (pre_fetch >= 0).
   task automatic do_load(input int n, input bit use_last, input bit gaps,
                          input int pre_fetch, input logic [7:0] pre_exp);
      load_start = 1'b1;
      if (pre_fetch >= 0) begin
         fetch_en   = 1'b1;
         fetch_addr = 4'(pre_fetch);
      end
      step();
      load_start = 1'b0;
      fetch_en   = 1'b0;
      if (pre_fetch >= 0) begin
         check("start_fetch valid", 32'(instr_valid), 32'd1);
         check("start_fetch instr", 32'(instr), 32'(pre_exp));
      end
      check("load_ready in LOAD", 32'(load_ready), 32'd1);
      check("fetch_ready in LOAD", 32'(fetch_ready), 32'd0);
      check("load_err cleared", 32'(load_err), 32'd0);
      for (int i = 0; i < n; i++) begin
         if (gaps && i > 0) begin
            load_valid = 1'b0;
            fetch_en   = 1'b1;
            fetch_addr = 4'd0;
            step();
            fetch_en = 1'b0;
            check("gap fetch blocked", 32'(instr_valid), 32'd0);
            check("gap fetch_ready", 32'(fetch_ready), 32'd0);
         end
         load_valid = 1'b1;
         load_data  = words[i];
         load_last  = use_last && (i == n - 1);
         step();
         if (i < n - 1) begin
            check($sformatf("no early done w%0d", i), 32'(load_done), 32'd0);
         end
      end
      load_valid = 1'b0;
      load_last  = 1'b0;
      check("load_done pulse", 32'(load_done), 32'd1);
      check("fetch_ready after load", 32'(fetch_ready), 32'd1);
      check("load_err after load", 32'(load_err), 32'(!use_last));
      step();
      check("load_done single", 32'(load_done), 32'd0);
   endtask

   initial begin
      vecs.push_back('{1, 4'd0,  8'hAD});
      vecs.push_back('{1, 4'd1,  8'hB6});
      vecs.push_back('{1, 4'd2,  8'h1A});
      vecs.push_back('{1, 4'd15, 8'hEF});
      vecs.push_back('{1, 4'd7,  8'h57});
      vecs.push_back('{2, 4'd0,  8'h11});
      vecs.push_back('{2, 4'd1,  8'h22});
      vecs.push_back('{2, 4'd2,  8'h33});
      vecs.push_back('{2, 4'd3,  8'h00});
      vecs.push_back('{2, 4'd15, 8'h00});
      vecs.push_back('{3, 4'd3,  8'hC3});
      vecs.push_back('{3, 4'd15, 8'hCF});
      vecs.push_back('{4, 4'd0,  8'h71});
      vecs.push_back('{4, 4'd1,  8'h72});
      vecs.push_back('{4, 4'd2,  8'h73});
      vecs.push_back('{4, 4'd3,  8'h74});
      vecs.push_back('{4, 4'd4,  8'h00});
      vecs.push_back('{5, 4'd0,  8'h81});
      vecs.push_back('{5, 4'd1,  8'h82});
      vecs.push_back('{5, 4'd2,  8'h00});
      vecs.push_back('{6, 4'd0,  8'h91});
      vecs.push_back('{6, 4'd1,  8'h92});
      vecs.push_back('{6, 4'd2,  8'h73});
      vecs.push_back('{6, 4'd15, 8'hCF});

      reset      = 1'b1;
      fetch_en   = 1'b0;
      fetch_addr = 4'd0;
      load_start = 1'b0;
      load_valid = 1'b0;
      load_data  = 8'h00;
      load_last  = 1'b0;
      step();
      step();
      check("rst instr", 32'(instr), 32'h00);
      check("rst instr_valid", 32'(instr_valid), 32'd0);
      check("rst load_done", 32'(load_done), 32'd0);
      check("rst load_err", 32'(load_err), 32'd0);
      check("rst prog_len", 32'(prog_len), 32'd16);
      check("rst fetch_ready", 32'(fetch_ready), 32'd1);
      check("rst load_ready", 32'(load_ready), 32'd0);
      reset = 1'b0;
      step();

      // Fill all 16 words (overflow), then reset: contents survive, len = 16.
      for (int i = 0; i < 16; i++) words[i] = 8'h50 + 8'(i);
      words[0] = 8'hAD; words[1] = 8'hB6; words[2] = 8'h1A; words[15] = 8'hEF;
      do_load(16, 1'b0, 1'b0, -1, 8'h00);
      check("ovf prog_len", 32'(prog_len), 32'd16);
      check("ovf err sticky", 32'(load_err), 32'd1);
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
      check("rst2 load_err", 32'(load_err), 32'd0);
      check("rst2 prog_len", 32'(prog_len), 32'd16);
      step();
      run_vecs(1);
      step();
      check("hold valid", 32'(instr_valid), 32'd0);
      check("hold instr", 32'(instr), 32'h57);

      // Short program with load_last.
      words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
      do_load(3, 1'b1, 1'b0, -1, 8'h00);
      check("len3 prog_len", 32'(prog_len), 32'd3);
      run_vecs(2);

      // Overflow again so the next load_start has an error to clear.
      for (int i = 0; i < 16; i++) words[i] = 8'hC0 + 8'(i);
      do_load(16, 1'b0, 1'b0, -1, 8'h00);
      check("ovf2 prog_len", 32'(prog_len), 32'd16);
      run_vecs(3);

      // Gapped load: valid every other cycle, fetch attempts in the gaps.
      words[0] = 8'h71; words[1] = 8'h72; words[2] = 8'h73; words[3] = 8'h74;
      do_load(4, 1'b1, 1'b1, -1, 8'h00);
      check("gap prog_len", 32'(prog_len), 32'd4);
      run_vecs(4);

      // Fetch in the load_start cycle sees the old word.
      words[0] = 8'h81; words[1] = 8'h82;
      do_load(2, 1'b1, 1'b0, 1, 8'h72);
      check("len2 prog_len", 32'(prog_len), 32'd2);
      run_vecs(5);

      // Reset after 2 of 5 words: abort, no done, written words kept.
      words[0] = 8'h91; words[1] = 8'h92;
      load_start = 1'b1;
      step();
      load_start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         load_valid = 1'b1;
         load_data  = words[i];
         step();
      end
      load_valid = 1'b1;
      load_data  = 8'h93;
      reset      = 1'b1;
      #1;
      load_valid = 1'b0;
      check("abort fetch_ready", 32'(fetch_ready), 32'd1);
      check("abort load_ready", 32'(load_ready), 32'd0);
      check("abort prog_len", 32'(prog_len), 32'd16);
      check("abort load_done", 32'(load_done), 32'd0);
      step();
      step();
      reset = 1'b0;
      step();
      check("abort no done", 32'(load_done), 32'd0);
      run_vecs(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
